sensor_init_seq: RTL

SENSOR_INIT_SEQ -- requirements
Module: sensor_init_seq

---
 rtl/sensor_init_seq_if.sv | 20 ++
 rtl/sensor_init_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sensor_init_seq_if.sv
// Register-write handshake between the init sequencer and the bus write stage.
// The sequencer drives address/data/start; the write stage answers with done/failure.
interface sensor_init_seq_if;
    logic [6:0] dev_address;
    logic [7:0] reg_address;
    logic [7:0] data;
    logic       start;
    logic       done;
    logic       failure;

    modport master (
        output dev_address, reg_address, data, start,
        input  done, failure
    );

    modport slave (
        input  dev_address, reg_address, data, start,
        output done, failure
    );
endinterface

// File: rtl/sensor_init_seq.sv
// Sensor init sequencer: walks a {reg,data} table, issuing one register write per
// entry, with per-entry retries, a write watchdog and in-table delay markers.
//
// state | meaning
// IDLE  | waiting for init_start
// LOAD  | latch table entry, decode end/delay/write
// ISSUE | wr start pulse
// WAIT  | waiting for done/failure, watchdog running
// GAP   | idle spacing before a retry
// DELAY | in-table delay countdown
// NEXT  | advance to the next entry
// DONE  | table finished
// ERROR | entry failed after all retries; entry_index holds it
module sensor_init_seq #(
    parameter logic [6:0]    DEV_ADDR    = 7'h21,
    parameter int            DELAY_UNIT  = 65536,
    parameter int            MAX_RETRIES = 3,
    parameter int            WD_CYCLES   = 1048576,
    parameter int            RETRY_GAP   = 256,
    parameter logic [4095:0] TABLE       = {{254{16'hFFFF}}, 16'h1101, 16'h1280}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init_start,
    sensor_init_seq_if.master wr,
    output logic              init_busy,
    output logic              init_done,
    output logic              init_error,
    output logic [7:0]        entry_index
);

    typedef enum logic [3:0] {
        IDLE, LOAD, ISSUE, WAIT, GAP, DELAY, NEXT, DONE, ERROR
    } state_t;

    localparam logic [23:0] DU       = 24'(DELAY_UNIT);
    localparam logic [23:0] WD_LAST  = 24'(WD_CYCLES - 1);
    localparam logic [23:0] GAP_LAST = 24'(RETRY_GAP - 1);
    localparam logic [7:0]  MAX_R    = 8'(MAX_RETRIES);

    state_t      state;
    logic [23:0] timer;
    logic [7:0]  retries;
    logic [15:0] rom;
    logic        write_failed;

    assign rom            = TABLE[{entry_index, 4'b0000} +: 16];
    assign wr.dev_address = DEV_ADDR;
    // failure flag wins over a simultaneous done; the watchdog expires at timer 0
    assign write_failed   = wr.failure || (!wr.done && timer == 24'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            timer          <= 24'd0;
            retries        <= 8'd0;
            entry_index    <= 8'd0;
            wr.reg_address <= 8'h00;
            wr.data        <= 8'h00;
            wr.start       <= 1'b0;
            init_busy      <= 1'b0;
            init_done      <= 1'b0;
            init_error     <= 1'b0;
        end else begin
            wr.start <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (init_start) begin
                        state       <= LOAD;
                        entry_index <= 8'd0;
                        retries     <= 8'd0;
                        init_busy   <= 1'b1;
                        init_done   <= 1'b0;
                        init_error  <= 1'b0;
                    end
                end
                LOAD: begin
                    wr.reg_address <= rom[15:8];
                    wr.data        <= rom[7:0];
                    if (rom == 16'hFFFF) begin
                        state     <= DONE;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end else if (rom[15:8] == 8'hFF) begin
                        if (rom[7:0] == 8'h00) begin
                            state <= NEXT;
                        end else begin
                            state <= DELAY;
                            timer <= {16'd0, rom[7:0]} * DU - 24'd1;
                        end
                    end else begin
                        state    <= ISSUE;
                        wr.start <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    timer <= WD_LAST;
                end
                WAIT: begin
                    if (write_failed) begin
                        if (retries < MAX_R) begin
                            retries <= retries + 8'd1;
                            timer   <= GAP_LAST;
                            state   <= GAP;
                        end else begin
                            state      <= ERROR;
                            init_busy  <= 1'b0;
                            init_error <= 1'b1;
                        end
                    end else if (wr.done) begin
                        state <= NEXT;
                    end else begin
                        timer <= timer - 24'd1;
                    end
                end
                GAP: begin
                    if (timer == 24'd0) begin
                        state    <= ISSUE;
                        wr.start <= 1'b1;
                    end else begin
                        timer <= timer - 24'd1;
                    end
                end
                DELAY: begin
                    if (timer == 24'd0) state <= NEXT;
                    else                timer <= timer - 24'd1;
                end
                NEXT: begin
                    retries <= 8'd0;
                    if (entry_index == 8'hFF) begin
                        state     <= DONE;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        entry_index <= entry_index + 8'd1;
                        state       <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
